sl_rx_ctrl: RTL and testbench
=============================

# sl_rx_ctrl

Host-side controller for one SL receiver channel. It sequences configuration writes into the receiver and retries each one until the receiver latches it. It captures completed SL words into a small FIFO and exposes config, data and status through a one-hot-addressed register port. It also raises an interrupt according to the receiver's IRQM config bit.

## Interface
Parameters:
- FIFO_DEPTH, 4: captured-word FIFO depth (2..7).
- RETRY_MAX, 1023: cycles to wait for the receiver to latch a config before giving up.

Ports:
- clk  in  1  system clock (16 MHz).
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- addr  in  4  one-hot register select: 0001 CONFIG, 0010 DATA_WR, 0100 DATA_R, 1000 STATUS.
- wr_en  in  1  host write strobe, single cycle.
- rd_en  in  1  host read strobe, single cycle.
- wdata  in  32  host write data; CONFIG uses [15:0].
- rdata  out  32  registered read data.
- ready  out  1  high when a CONFIG write is accepted; equals !cfg_busy.
- irq  out  1  interrupt request.
- rx_status_w  in  16  receiver status: WLC[0], WRP[1], WRF[3], PEF[4], LEF[5].
- rx_data_w  in  32  receiver's last received word.
- rx_config_w  in  16  receiver's current config: PCE[0], BQ[6:1], MODE[7], IRQM[8].
- rx_wr_config_w  out  16  config value offered to the receiver.
- rx_wr_enable  out  1  config write request to the receiver.

## Operation
Config FSM, states CFG_IDLE, CFG_PUSH, CFG_DONE:
- CFG_IDLE + wr_en + addr=CONFIG:
  - If wdata[6:1] is outside 9..32, set sticky CFG_REJ and stay idle.
  - Otherwise latch pend_cfg and go to CFG_PUSH.
- CFG_PUSH: drive rx_wr_config_w=pend_cfg with rx_wr_enable=1 and increment retry_cnt.
  - rx_config_w==pend_cfg → CFG_DONE.
  - retry_cnt==RETRY_MAX → set sticky CFG_FAIL, go to CFG_DONE.
- CFG_DONE: drop rx_wr_enable, clear retry_cnt, return to CFG_IDLE.
- cfg_busy = (state != CFG_IDLE).
- CONFIG writes while busy are ignored; no flag is set.

Word capture:
- wrf_q is a registered copy of rx_status_w[3]. A rising edge of WRF is a word event.
- Event with PEF=0 and WLC=0: push rx_data_w into the FIFO.
  - If the FIFO is full, drop the word and set sticky OVF.
- Event with PEF=1 or WLC=1: increment err_cnt (8-bit, saturating at 255). Nothing is pushed.
- Rising edge of LEF also increments err_cnt.

Host reads (rdata registered, valid the cycle after rd_en):
- CONFIG returns {16'h0, rx_config_w}.
- DATA_R pops the FIFO head. If the FIFO is empty it returns 0 and changes nothing.
- DATA_WR returns 0; writes to DATA_WR are ignored (reserved for TX).
- STATUS returns the layout below, then clears OVF, CFG_FAIL, CFG_REJ and err_cnt in the same cycle.

STATUS layout: [3:0] count, [4] empty, [5] full, [6] OVF, [7] cfg_busy, [8] CFG_FAIL, [9] CFG_REJ, [10] rx WRP mirror, [23:16] err_cnt, all other bits 0.

IRQ, selected by rx_config_w[8]:
- IRQM=0: irq is a level, equal to FIFO non-empty.
- IRQM=1: irq is a one-cycle pulse for each successful push.

## Timing
- Reset values:
  - rdata=0, irq=0, ready=1, rx_wr_enable=0, rx_wr_config_w=0.
  - FIFO empty, all sticky bits 0, err_cnt=0, wrf_q=0, config FSM in CFG_IDLE.
- Push latency: the word is in the FIFO, and counted, one cycle after WRF rises. An IRQM=1 pulse appears in that same cycle.
- Pop latency: rdata holds the head in the cycle after rd_en. count decrements in that same cycle.
- Push and pop in the same cycle:
  - FIFO full: both happen, count unchanged, no OVF.
  - FIFO empty: the pop returns 0 and the push lands.
- STATUS read in the same cycle as a sticky-setting event: the new event wins and the bit stays set. A simultaneous error event leaves err_cnt=1.
- FIFO pointers are mod FIFO_DEPTH and wrap without a gap.
- Config, receiver idle: the receiver latches on the first rx_wr_enable cycle, so ready returns 3 cycles after wr_en.
- Config, mid-word: rx_wr_enable is held until the receiver reaches word boundary.
- Reset asserted mid-operation clears everything immediately, including a pending config. rx_wr_enable drops asynchronously.

## Structure
- Shared package sl_pkg holds:
  - register address one-hots;
  - receiver config field indices (PCE, BQL, BQH, MODE, IRQM);
  - receiver status indices (WLC, WRP, WRF, PEF, LEF);
  - controller STATUS bit indices;
  - config FSM state encoding.
- Sub-module sl_rx_fifo: synchronous FIFO parameterized by width and depth, with push, pop, full, empty and count.

## Test plan
- Reset release, then STATUS read → rdata=0x00000010 (empty=1); irq=0, ready=1.
- CONFIG write 0x0110 (BQ=8) → CFG_REJ=1, rx_wr_enable never asserted. CONFIG write 0x0041 (BQ=32, PCE) with the model latching after 5 cycles → rx_wr_enable high for 5 cycles, ready low, then CONFIG read=0x0041.
- Model never latches the config → CFG_FAIL set after RETRY_MAX+1 cycles, ready=1; a second STATUS read shows CFG_FAIL=0.
- Five clean words 0x11..0x55 with FIFO_DEPTH=4, IRQM=0 → irq=1, full=1, OVF=1. Four DATA_R reads return 0x11, 0x22, 0x33, 0x44; irq=0 afterwards.
- WRF edge with PEF=1, then with WLC=1, then a LEF edge → err_cnt=3, no push; IRQM=1 gives no irq pulse.
- FIFO full, and a DATA_R pop coincides with a new word 0x66 → count stays 4, OVF=0, 0x66 is read last.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared definitions for the SL receiver-channel controller: register map,
// receiver config/status bit positions, controller STATUS layout and FSM states.
package sl_pkg;

  localparam logic [3:0] ADDR_CONFIG  = 4'b0001;
  localparam logic [3:0] ADDR_DATA_WR = 4'b0010;
  localparam logic [3:0] ADDR_DATA_R  = 4'b0100;
  localparam logic [3:0] ADDR_STATUS  = 4'b1000;

  localparam int CFG_PCE  = 0;
  localparam int CFG_BQL  = 1;
  localparam int CFG_BQH  = 6;
  localparam int CFG_MODE = 7;
  localparam int CFG_IRQM = 8;

  localparam int ST_WLC = 0;
  localparam int ST_WRP = 1;
  localparam int ST_WRF = 3;
  localparam int ST_PEF = 4;
  localparam int ST_LEF = 5;

  localparam int STS_CNTL  = 0;
  localparam int STS_CNTH  = 3;
  localparam int STS_EMPTY = 4;
  localparam int STS_FULL  = 5;
  localparam int STS_OVF   = 6;
  localparam int STS_BUSY  = 7;
  localparam int STS_FAIL  = 8;
  localparam int STS_REJ   = 9;
  localparam int STS_WRP   = 10;
  localparam int STS_ERRL  = 16;
  localparam int STS_ERRH  = 23;

  localparam logic [5:0] BQ_MIN = 6'd9;
  localparam logic [5:0] BQ_MAX = 6'd32;

  typedef enum logic [1:0] {
    CFG_IDLE = 2'd0,
    CFG_PUSH = 2'd1,
    CFG_DONE = 2'd2
  } cfg_state_t;

  // A config is only offered to the receiver when its bit-quantity field is legal.
  function automatic logic bq_valid(input logic [15:0] cfg);
    logic [5:0] bq;
    bq = cfg[CFG_BQH:CFG_BQL];
    return (bq >= BQ_MIN) && (bq <= BQ_MAX);
  endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// Small synchronous FIFO for captured SL words; pointers wrap modulo DEPTH,
// so non-power-of-two depths use every slot.
module sl_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST) return {PW{1'b0}};
    else return p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sl_rx_ctrl.sv
// Host-side controller for one SL receiver channel: config push/retry FSM,
// captured-word FIFO, error counting, register port and interrupt.
module sl_rx_ctrl
  import sl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RETRY_MAX  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq,
  input  logic [15:0] rx_status_w,
  input  logic [31:0] rx_data_w,
  input  logic [15:0] rx_config_w,
  output logic [15:0] rx_wr_config_w,
  output logic        rx_wr_enable
);

  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  cfg_state_t    state;
  cfg_state_t    state_nxt;
  logic [15:0]   pend_cfg;
  logic [RW-1:0] retry_cnt;
  logic          cfg_busy;
  logic          cfg_match;
  logic          retry_hit;
  logic          cfg_accept;
  logic          cfg_reject;
  logic          cfg_timeout;
  logic          wr_cfg;
  logic          rd_dat;
  logic          rd_sts;

  logic          cfg_fail;
  logic          cfg_rej;
  logic          ovf;
  logic [7:0]    err_cnt;
  logic [7:0]    err_base;
  logic [8:0]    err_sum;
  logic [7:0]    err_nxt;
  logic [1:0]    err_inc;
  logic          wrf_q;
  logic          lef_q;
  logic          wrf_rise;
  logic          lef_rise;
  logic          word_bad;
  logic          word_ok;
  logic          word_drop;

  logic          push;
  logic          pop;
  logic [31:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count4;
  logic [3:0]    count_nxt;
  logic          irq_nxt;
  logic [31:0]   status_word;
  logic [31:0]   rdata_nxt;
  logic          unused_bits;

  assign unused_bits = ^{wdata[31:16], rx_status_w[15:6], rx_status_w[2]};

  assign wr_cfg    = wr_en && (addr == ADDR_CONFIG);
  assign rd_dat    = rd_en && (addr == ADDR_DATA_R);
  assign rd_sts    = rd_en && (addr == ADDR_STATUS);
  assign cfg_busy  = (state != CFG_IDLE);
  assign cfg_match = (rx_config_w == pend_cfg);
  assign retry_hit = (retry_cnt == RW'(RETRY_MAX));
  assign rx_wr_config_w = pend_cfg;

  // Config sequencing: a successful latch takes priority over the retry limit.
  always_comb begin
    state_nxt   = state;
    cfg_accept  = 1'b0;
    cfg_reject  = 1'b0;
    cfg_timeout = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (wr_cfg) begin
          if (bq_valid(wdata[15:0])) begin
            cfg_accept = 1'b1;
            state_nxt  = CFG_PUSH;
          end else begin
            cfg_reject = 1'b1;
            state_nxt  = CFG_IDLE;
          end
        end else begin
          state_nxt = CFG_IDLE;
        end
      end
      CFG_PUSH: begin
        if (cfg_match) begin
          state_nxt = CFG_DONE;
        end else if (retry_hit) begin
          cfg_timeout = 1'b1;
          state_nxt   = CFG_DONE;
        end else begin
          state_nxt = CFG_PUSH;
        end
      end
      CFG_DONE: state_nxt = CFG_IDLE;
      default:  state_nxt = CFG_IDLE;
    endcase
  end

  // Config FSM state, pending value, retry counter and the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CFG_IDLE;
      pend_cfg     <= 16'd0;
      retry_cnt    <= {RW{1'b0}};
      rx_wr_enable <= 1'b0;
      ready        <= 1'b1;
    end else begin
      state        <= state_nxt;
      rx_wr_enable <= (state_nxt == CFG_PUSH);
      ready        <= (state_nxt == CFG_IDLE);
      if (cfg_accept) pend_cfg <= wdata[15:0];
      if (state == CFG_PUSH) retry_cnt <= retry_cnt + RW'(1);
      else                   retry_cnt <= {RW{1'b0}};
    end
  end

  assign wrf_rise  = rx_status_w[ST_WRF] & ~wrf_q;
  assign lef_rise  = rx_status_w[ST_LEF] & ~lef_q;
  assign word_bad  = rx_status_w[ST_PEF] | rx_status_w[ST_WLC];
  assign word_ok   = wrf_rise & ~word_bad;
  assign pop       = rd_dat && !fifo_empty;
  assign push      = word_ok && (!fifo_full || pop);
  assign word_drop = word_ok && fifo_full && !pop;
  assign err_inc   = {1'b0, wrf_rise & word_bad} + {1'b0, lef_rise};

  // A STATUS read clears the counter, but errors arriving in that cycle still count.
  always_comb begin
    err_base = rd_sts ? 8'd0 : err_cnt;
    err_sum  = {1'b0, err_base} + {7'd0, err_inc};
    if (err_sum[8]) err_nxt = 8'hFF;
    else            err_nxt = err_sum[7:0];
  end

  // Edge detectors, sticky flags and the error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrf_q    <= 1'b0;
      lef_q    <= 1'b0;
      cfg_fail <= 1'b0;
      cfg_rej  <= 1'b0;
      ovf      <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      wrf_q    <= rx_status_w[ST_WRF];
      lef_q    <= rx_status_w[ST_LEF];
      cfg_fail <= cfg_timeout | (cfg_fail & ~rd_sts);
      cfg_rej  <= cfg_reject  | (cfg_rej  & ~rd_sts);
      ovf      <= word_drop   | (ovf      & ~rd_sts);
      err_cnt  <= err_nxt;
    end
  end

  sl_rx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data_w),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count4 = 4'(fifo_count);

  // irq follows the post-update occupancy so it lines up with the registered FIFO state.
  always_comb begin
    count_nxt = count4;
    if (push && !pop)      count_nxt = count4 + 4'd1;
    else if (pop && !push) count_nxt = count4 - 4'd1;
    else                   count_nxt = count4;
    if (rx_config_w[CFG_IRQM]) irq_nxt = push;
    else                       irq_nxt = (count_nxt != 4'd0);
  end

  // Assembly of the host-visible STATUS word.
  always_comb begin
    status_word                      = 32'd0;
    status_word[STS_CNTH:STS_CNTL]   = count4;
    status_word[STS_EMPTY]           = fifo_empty;
    status_word[STS_FULL]            = fifo_full;
    status_word[STS_OVF]             = ovf;
    status_word[STS_BUSY]            = cfg_busy;
    status_word[STS_FAIL]            = cfg_fail;
    status_word[STS_REJ]             = cfg_rej;
    status_word[STS_WRP]             = rx_status_w[ST_WRP];
    status_word[STS_ERRH:STS_ERRL]   = err_cnt;
  end

  // Read-data mux; rdata holds its value between reads.
  always_comb begin
    rdata_nxt = rdata;
    if (rd_en) begin
      case (addr)
        ADDR_CONFIG:  rdata_nxt = {16'd0, rx_config_w};
        ADDR_DATA_R:  rdata_nxt = fifo_empty ? 32'd0 : fifo_head;
        ADDR_STATUS:  rdata_nxt = status_word;
        ADDR_DATA_WR: rdata_nxt = 32'd0;
        default:      rdata_nxt = 32'd0;
      endcase
    end else begin
      rdata_nxt = rdata;
    end
  end

  // Registered host-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
      irq   <= 1'b0;
    end else begin
      rdata <= rdata_nxt;
      irq   <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Directed, scoreboard-based bench for sl_rx_ctrl with a behavioural receiver
// that latches offered configs after a programmable number of enable cycles.
module tb_sl_rx_ctrl;
  import sl_pkg::*;

  localparam int DEPTH = 4;
  localparam int RMAX  = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;
  logic [15:0] rx_status_w;
  logic [31:0] rx_data_w;
  logic [15:0] rx_cfg = 16'd0;
  logic [15:0] rx_wr_config_w;
  logic        rx_wr_enable;

  int tests = 0;
  int fails = 0;
  int latch_after = 1;
  int en_run = 0;
  int en_seen = 0;
  logic irqm;
  int nl;
  int ne;

  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  string       tag_q[$];

  sl_rx_ctrl #(.FIFO_DEPTH(DEPTH), .RETRY_MAX(RMAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .addr           (addr),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .wdata          (wdata),
    .rdata          (rdata),
    .ready          (ready),
    .irq            (irq),
    .rx_status_w    (rx_status_w),
    .rx_data_w      (rx_data_w),
    .rx_config_w    (rx_cfg),
    .rx_wr_config_w (rx_wr_config_w),
    .rx_wr_enable   (rx_wr_enable)
  );

  always #5 clk = ~clk;

  // Receiver model: latch_after=N makes the new config visible in the (N+1)th enable
  // cycle (N=1 is an idle receiver); 0 means it never latches.
  always @(posedge clk) begin
    en_seen <= en_seen + (rx_wr_enable ? 1 : 0);
    if (rx_wr_enable) begin
      if (latch_after != 0 && en_run + 1 == latch_after) rx_cfg <= rx_wr_config_w;
      en_run <= en_run + 1;
    end else begin
      en_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pop();
    if (model_q.size() == 0) return 32'd0;
    return model_q.pop_front();
  endfunction

  task automatic sb_check();
    check(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  task automatic read_reg(input logic [3:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 4'd0;
    sb_check();
  endtask

  task automatic send_word(input logic [31:0] d, input logic pef, input logic wlc, input string tag);
    logic pushed;
    pushed = 1'b0;
    if (!pef && !wlc && model_q.size() < DEPTH) begin
      model_q.push_back(d);
      pushed = 1'b1;
    end
    rx_data_w = d;
    rx_status_w[ST_WRF] = 1'b1;
    rx_status_w[ST_PEF] = pef;
    rx_status_w[ST_WLC] = wlc;
    @(negedge clk);
    check({tag, "_irq1"}, 32'(irq), irqm ? 32'(pushed) : 32'(model_q.size() != 0));
    rx_status_w[ST_WRF] = 1'b0;
    rx_status_w[ST_PEF] = 1'b0;
    rx_status_w[ST_WLC] = 1'b0;
    @(negedge clk);
    check({tag, "_irq2"}, 32'(irq), irqm ? 32'd0 : 32'(model_q.size() != 0));
  endtask

  task automatic cfg_write(input logic [15:0] v, input int latch, input logic poke,
                           input logic [15:0] pv, output int n_low, output int n_en);
    int en0;
    latch_after = latch;
    en0   = en_seen;
    addr  = ADDR_CONFIG;
    wdata = {16'd0, v};
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    n_low = 0;
    while (!ready && n_low < 2000) begin
      if (n_low == 0 && poke) begin
        wdata = {16'd0, pv};
        wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      n_low++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    addr  = 4'd0;
    n_en  = en_seen - en0;
    check("cfg_ready_back", 32'(ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; addr = 4'd0; wr_en = 1'b0; rd_en = 1'b0; wdata = 32'd0;
    rx_status_w = 16'd0; rx_data_w = 32'd0; irqm = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_wr_enable", 32'(rx_wr_enable), 32'd0);
    check("rst_wr_config", 32'(rx_wr_config_w), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    read_reg(ADDR_STATUS, 32'h0000_0010, "reset_status");

    cfg_write(16'h0013, 1, 1'b0, 16'h0, nl, ne);
    check("cfg_idle_ready_low", 32'(nl), 32'd3);
    check("cfg_idle_en_cycles", 32'(ne), 32'd2);
    read_reg(ADDR_CONFIG, 32'h0000_0013, "cfg_idle_readback");

    cfg_write(16'h0110, 1, 1'b0, 16'h0, nl, ne);
    check("rej_bq8_ready", 32'(nl), 32'd0);
    check("rej_bq8_en", 32'(ne), 32'd0);
    cfg_write(16'h0042, 1, 1'b0, 16'h0, nl, ne);
    check("rej_bq33_en", 32'(ne), 32'd0);
    read_reg(ADDR_STATUS, 32'h0000_0210, "rej_status");
    read_reg(ADDR_STATUS, 32'h0000_0010, "rej_cleared");

    cfg_write(16'h0041, 4, 1'b1, 16'h0013, nl, ne);
    check("cfg_slow_en_cycles", 32'(ne), 32'd5);
    check("cfg_slow_ready_low", 32'(nl), 32'd6);
    read_reg(ADDR_CONFIG, 32'h0000_0041, "cfg_slow_readback");
    read_reg(ADDR_STATUS, 32'h0000_0010, "busy_write_no_flag");

    cfg_write(16'h0021, 0, 1'b0, 16'h0, nl, ne);
    check("cfg_fail_en_cycles", 32'(ne), 32'(RMAX + 1));
    read_reg(ADDR_STATUS, 32'h0000_0110, "cfg_fail_status");
    read_reg(ADDR_STATUS, 32'h0000_0010, "cfg_fail_cleared");
    read_reg(ADDR_CONFIG, 32'h0000_0041, "cfg_fail_unchanged");

    irqm = 1'b0;
    for (int i = 1; i <= 5; i++) send_word(32'(i * 17), 1'b0, 1'b0, "word");
    check("full_irq_level", 32'(irq), 32'd1);
    read_reg(ADDR_STATUS, 32'h0000_0064, "full_ovf_status");
    for (int i = 0; i < 4; i++) read_reg(ADDR_DATA_R, model_pop(), "drain_data");
    check("drained_irq", 32'(irq), 32'd0);
    read_reg(ADDR_DATA_R, model_pop(), "empty_pop_zero");
    read_reg(ADDR_STATUS, 32'h0000_0010, "drained_status");

    cfg_write(16'h0141, 1, 1'b0, 16'h0, nl, ne);
    irqm = 1'b1;
    send_word(32'h0000_0099, 1'b1, 1'b0, "pef_word");
    send_word(32'h0000_0098, 1'b0, 1'b1, "wlc_word");
    rx_status_w[ST_LEF] = 1'b1;
    @(negedge clk);
    rx_status_w[ST_LEF] = 1'b0;
    @(negedge clk);
    check("lef_irq", 32'(irq), 32'd0);
    read_reg(ADDR_STATUS, 32'h0003_0010, "err_cnt_3");
    read_reg(ADDR_STATUS, 32'h0000_0010, "err_cnt_cleared");
    send_word(32'h0000_005A, 1'b0, 1'b0, "pulse_word");
    read_reg(ADDR_DATA_R, model_pop(), "pulse_word_data");

    for (int i = 1; i <= 4; i++) send_word(32'hA0 + 32'(i), 1'b0, 1'b0, "fill");
    addr = ADDR_DATA_R; rd_en = 1'b1;
    exp_q.push_back(model_pop());
    tag_q.push_back("full_pop_push_data");
    model_q.push_back(32'h0000_0066);
    rx_data_w = 32'h0000_0066;
    rx_status_w[ST_WRF] = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; addr = 4'd0; rx_status_w[ST_WRF] = 1'b0;
    sb_check();
    check("full_pop_push_irq", 32'(irq), 32'd1);
    @(negedge clk);
    read_reg(ADDR_STATUS, 32'h0000_0024, "full_pop_push_status");
    for (int i = 0; i < 4; i++) read_reg(ADDR_DATA_R, model_pop(), "after_wrap_data");

    addr = ADDR_STATUS; rd_en = 1'b1;
    exp_q.push_back(32'h0000_0010);
    tag_q.push_back("sts_with_err");
    rx_status_w[ST_WRF] = 1'b1; rx_status_w[ST_PEF] = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; addr = 4'd0; rx_status_w[ST_WRF] = 1'b0; rx_status_w[ST_PEF] = 1'b0;
    sb_check();
    @(negedge clk);
    read_reg(ADDR_STATUS, 32'h0001_0010, "err_survives_clear");

    addr = ADDR_DATA_R; rd_en = 1'b1;
    exp_q.push_back(model_pop());
    tag_q.push_back("empty_pop_push_data");
    model_q.push_back(32'h0000_0077);
    rx_data_w = 32'h0000_0077;
    rx_status_w[ST_WRF] = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; addr = 4'd0; rx_status_w[ST_WRF] = 1'b0;
    sb_check();
    @(negedge clk);
    read_reg(ADDR_STATUS, 32'h0000_0001, "empty_pop_push_status");
    read_reg(ADDR_DATA_R, model_pop(), "empty_pop_push_word");

    rx_status_w[ST_WRP] = 1'b1;
    read_reg(ADDR_STATUS, 32'h0000_0410, "wrp_mirror");
    rx_status_w[ST_WRP] = 1'b0;

    send_word(32'h0000_0088, 1'b0, 1'b0, "pre_reset_word");
    latch_after = 0;
    addr = ADDR_CONFIG; wdata = 32'h0000_0021; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; addr = 4'd0;
    repeat (3) @(negedge clk);
    check("midrst_en_before", 32'(rx_wr_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_en_async", 32'(rx_wr_enable), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_cfg_cleared", 32'(rx_wr_config_w), 32'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_reg(ADDR_STATUS, 32'h0000_0010, "midrst_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
